// File: rtl/dac_port_ctrl_if.sv
// dac_port_ctrl_if: CPU-side DAC port bus plus palette RAM port B.
// master = CPU / palette RAM side, slave = dac_port_ctrl.
interface dac_port_ctrl_if #(
   parameter int unsigned PAL_DEPTH_LOG2 = 8
);
   logic [1:0]                io_a;
   logic                      io_wr;
   logic                      io_rd;
   logic [7:0]                io_d;
   logic [7:0]                io_q;
   logic                      busy;
   logic [PAL_DEPTH_LOG2-1:0] pal_a;
   logic [11:0]               pal_d;
   logic                      pal_we;
   logic [11:0]               pal_q;

   modport master (
      output io_a, io_wr, io_rd, io_d, pal_q,
      input  io_q, busy, pal_a, pal_d, pal_we
   );

   modport slave (
      input  io_a, io_wr, io_rd, io_d, pal_q,
      output io_q, busy, pal_a, pal_d, pal_we
   );
endinterface

// File: rtl/dac_port_ctrl.sv
// dac_port_ctrl: VGA-style DAC port (write index, read index, R/G/B data port) in front of
// port B of the palette RAM. Palette writes and read-back prefetches share that port; a
// pending write always wins and the prefetch address cycle slips one clock.
// Optional macro DAC_8BIT_EN: 8-bit CPU components instead of 6-bit VGA components.
module dac_port_ctrl #(
   parameter int unsigned PAL_DEPTH_LOG2 = 8,
   parameter int unsigned READ_LAT       = 1
) (
   input logic           clock,
   input logic           reset_n,
   dac_port_ctrl_if.slave bus
);
   localparam int unsigned AW       = PAL_DEPTH_LOG2;
   localparam logic [7:0]  LAT_LAST = 8'(READ_LAT - 1);

   typedef enum logic [1:0] {StIdle, StAddr, StWait, StLatch} state_t;
   typedef enum logic {ModeWrite, ModeRead} mode_t;

   // CPU-side state
   logic [AW-1:0] widx, ridx, wr_addr;
   logic [1:0]    wcomp, rcomp;
   logic [3:0]    r_acc, g_acc;
   logic [11:0]   wr_data;
   logic          wr_pend;
   mode_t         mode;
   logic [7:0]    io_q;

   // Palette-port / prefetch state
   state_t        state;
   logic          busy;
   logic          addr_ok;
   logic [7:0]    lat_cnt;
   logic [AW-1:0] pal_a;
   logic [11:0]   pal_d;
   logic          pal_we;
   logic [11:0]   rbuf;

   // Decoded strobes
   logic          wr_ridx, wr_widx, wr_dat, rd_en, rd_data_ok, restart, start;
   logic [AW-1:0] start_addr;
   logic [3:0]    c_in, c_out;
   logic [7:0]    rd_comp;

   assign bus.io_q   = io_q;
   assign bus.busy   = busy;
   assign bus.pal_a  = pal_a;
   assign bus.pal_d  = pal_d;
   assign bus.pal_we = pal_we;

   // Decode CPU strobes and format components in both directions.
   always_comb begin
      wr_ridx    = bus.io_wr && (bus.io_a == 2'd0);
      wr_widx    = bus.io_wr && (bus.io_a == 2'd1);
      wr_dat     = bus.io_wr && (bus.io_a == 2'd2);
      // A write in the same cycle swallows the read.
      rd_en      = bus.io_rd && !bus.io_wr;
      rd_data_ok = rd_en && (bus.io_a == 2'd2) && (mode == ModeRead) && !busy;
      restart    = rd_data_ok && (rcomp == 2'd2);
      start      = wr_ridx || restart;
      start_addr = wr_ridx ? AW'(bus.io_d) : ridx + 1'b1;

      c_out = rbuf[3:0];
      case (rcomp)
         2'd0:    c_out = rbuf[11:8];
         2'd1:    c_out = rbuf[7:4];
         default: c_out = rbuf[3:0];
      endcase

`ifdef DAC_8BIT_EN
      c_in    = bus.io_d[7:4];
      rd_comp = {c_out, c_out};
`else
      c_in    = bus.io_d[5:2];
      rd_comp = {2'b00, c_out, c_out[3:2]};
`endif
   end

   // CPU register file: indices, component counters, accumulators and read data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         widx    <= '0;
         ridx    <= '0;
         wcomp   <= 2'd0;
         rcomp   <= 2'd0;
         mode    <= ModeWrite;
         r_acc   <= 4'd0;
         g_acc   <= 4'd0;
         wr_pend <= 1'b0;
         wr_addr <= '0;
         wr_data <= 12'd0;
         io_q    <= 8'h00;
      end else begin
         wr_pend <= 1'b0;
         if (wr_widx) begin
            widx  <= AW'(bus.io_d);
            wcomp <= 2'd0;
            mode  <= ModeWrite;
         end
         if (wr_ridx) begin
            ridx  <= AW'(bus.io_d);
            rcomp <= 2'd0;
            mode  <= ModeRead;
         end
         if (wr_dat) begin
            case (wcomp)
               2'd0: begin
                  r_acc <= c_in;
                  wcomp <= 2'd1;
               end
               2'd1: begin
                  g_acc <= c_in;
                  wcomp <= 2'd2;
               end
               default: begin
                  // Entry complete: hand it to the port sequencer next clock.
                  wr_pend <= 1'b1;
                  wr_addr <= widx;
                  wr_data <= {r_acc, g_acc, c_in};
                  widx    <= widx + 1'b1;
                  wcomp   <= 2'd0;
               end
            endcase
         end
         if (rd_en) begin
            case (bus.io_a)
               2'd0: io_q <= (mode == ModeRead) ? 8'h03 : 8'h00;
               2'd1: io_q <= 8'(widx);
               2'd2: begin
                  if (rd_data_ok) begin
                     io_q <= rd_comp;
                     if (rcomp == 2'd2) begin
                        rcomp <= 2'd0;
                        ridx  <= ridx + 1'b1;
                     end else begin
                        rcomp <= rcomp + 2'd1;
                     end
                  end else begin
                     io_q <= 8'h00;
                  end
               end
               default: io_q <= 8'h00;
            endcase
         end
      end
   end

   // Palette port B sequencer: issues pending writes and runs the read-back prefetch FSM.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= StIdle;
         busy    <= 1'b0;
         addr_ok <= 1'b0;
         lat_cnt <= 8'd0;
         pal_a   <= '0;
         pal_d   <= 12'd0;
         pal_we  <= 1'b0;
         rbuf    <= 12'd0;
      end else begin
         pal_we <= wr_pend;
         if (wr_pend) begin
            pal_a <= wr_addr;
            pal_d <= wr_data;
         end
         if (start) begin
            // addr_ok low means the write took the port; the address goes out next clock.
            state   <= StAddr;
            busy    <= 1'b1;
            lat_cnt <= 8'd0;
            addr_ok <= !wr_pend;
            if (!wr_pend) begin
               pal_a <= start_addr;
            end
         end else if (wr_widx) begin
            state <= StIdle;
            busy  <= 1'b0;
         end else begin
            case (state)
               StAddr: begin
                  if (addr_ok) begin
                     state <= StWait;
                  end else if (!wr_pend) begin
                     pal_a   <= ridx;
                     addr_ok <= 1'b1;
                  end
               end
               StWait: begin
                  if (lat_cnt == LAT_LAST) begin
                     state <= StLatch;
                     rbuf  <= bus.pal_q;
                  end else begin
                     lat_cnt <= lat_cnt + 8'd1;
                  end
               end
               StLatch: begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dac_port_ctrl.sv
// tb_dac_port_ctrl: scoreboard bench for dac_port_ctrl (default 6-bit build, READ_LAT=1).
// Expected palette writes and CPU read data are queued when stimulus is driven and
// popped when the DUT produces them.
module tb_dac_port_ctrl;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   dac_port_ctrl_if #(.PAL_DEPTH_LOG2(8)) bus ();

   dac_port_ctrl #(
      .PAL_DEPTH_LOG2(8),
      .READ_LAT      (1)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic [7:0]  a;
      logic [11:0] d;
   } pw_t;

   int          checks = 0;
   int          fails  = 0;
   pw_t         wq[$];
   logic [7:0]  rq[$];
   logic [11:0] mem[256];
   logic        prev_we = 1'b0;

   // Synchronous palette RAM, one clock read latency.
   always @(posedge clock) begin
      if (bus.pal_we) mem[bus.pal_a] <= bus.pal_d;
      bus.pal_q <= mem[bus.pal_a];
   end

   // Palette-write monitor: every pal_we cycle must match the next queued write.
   always @(negedge clock) begin
      pw_t e;
      if (bus.pal_we) begin
         checks++;
         if (wq.size() == 0) begin
            fails++;
            $display("FAIL pal_we_unexpected: got a=%h d=%h, none expected", bus.pal_a, bus.pal_d);
         end else begin
            e = wq.pop_front();
            if ({bus.pal_a, bus.pal_d} !== e) begin
               fails++;
               $display("FAIL pal_write: got a=%h d=%h, expected a=%h d=%h",
                        bus.pal_a, bus.pal_d, e.a, e.d);
            end
         end
         if (prev_we) begin
            fails++;
            $display("FAIL pal_we_pulse: got pal_we high 2 clocks, expected 1");
         end
      end
      prev_we <= bus.pal_we;
   end

   // Stimulus tasks start and end on a falling edge so back-to-back calls are contiguous.
   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      bus.io_a  = a;
      bus.io_d  = d;
      bus.io_wr = 1'b1;
      @(negedge clock);
      bus.io_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic [1:0] a);
      bus.io_a  = a;
      bus.io_rd = 1'b1;
      @(negedge clock);
      bus.io_rd = 1'b0;
   endtask

   task automatic wait_not_busy(output int cycles);
      cycles = 0;
      while (bus.busy === 1'b1 && cycles < 50) begin
         @(negedge clock);
         cycles++;
      end
   endtask

   task automatic test_reset;
      logic [7:0] e;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({bus.io_q, bus.busy, bus.pal_we} !== 10'd0) begin
         fails++;
         $display("FAIL reset_outs: got io_q=%h busy=%b pal_we=%b, expected 00 0 0",
                  bus.io_q, bus.busy, bus.pal_we);
      end
      checks++;
      if ({bus.pal_a, bus.pal_d} !== 20'd0) begin
         fails++;
         $display("FAIL reset_pal: got a=%h d=%h, expected 00 000", bus.pal_a, bus.pal_d);
      end
      reset_n = 1'b1;
      @(negedge clock);
      rq.push_back(8'h00);
      cpu_read(2'd1);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL reset_widx: got %h, expected %h", bus.io_q, e);
      end
      rq.push_back(8'h00);
      cpu_read(2'd0);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL reset_status: got %h, expected %h", bus.io_q, e);
      end
   endtask

   task automatic test_write_path;
      logic [7:0] e;
      cpu_write(2'd1, 8'h10);
      wq.push_back('{a: 8'h10, d: 12'hF08});
      cpu_write(2'd2, 8'h3F);
      cpu_write(2'd2, 8'h00);
      cpu_write(2'd2, 8'h20);
      rq.push_back(8'h11);
      cpu_read(2'd1);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL widx_inc: got %h, expected %h", bus.io_q, e);
      end
      @(negedge clock);
   endtask

   task automatic test_wrap;
      logic [7:0] e;
      cpu_write(2'd1, 8'hFF);
      wq.push_back('{a: 8'hFF, d: 12'h123});
      cpu_write(2'd2, 8'h04);
      cpu_write(2'd2, 8'h08);
      cpu_write(2'd2, 8'h0C);
      rq.push_back(8'h00);
      cpu_read(2'd1);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL widx_wrap: got %h, expected %h", bus.io_q, e);
      end
      @(negedge clock);
   endtask

   task automatic test_read_back;
      logic [7:0] e;
      logic [7:0] exp3[3];
      int         cyc;
      exp3 = '{8'h2A, 8'h15, 8'h33};
      // Load entries 0x05 = A5C and 0x06 = 300 through the write path.
      cpu_write(2'd1, 8'h05);
      wq.push_back('{a: 8'h05, d: 12'hA5C});
      wq.push_back('{a: 8'h06, d: 12'h300});
      cpu_write(2'd2, 8'h28);
      cpu_write(2'd2, 8'h14);
      cpu_write(2'd2, 8'h30);
      cpu_write(2'd2, 8'h0C);
      cpu_write(2'd2, 8'h00);
      cpu_write(2'd2, 8'h00);
      repeat (2) @(negedge clock);
      cpu_write(2'd0, 8'h05);
      wait_not_busy(cyc);
      checks++;
      if (cyc != 3) begin
         fails++;
         $display("FAIL busy_len: got %0d clocks, expected 3", cyc);
      end
      rq.push_back(8'h03);
      cpu_read(2'd0);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL status_read: got %h, expected %h", bus.io_q, e);
      end
      for (int i = 0; i < 3; i++) begin
         rq.push_back(exp3[i]);
         cpu_read(2'd2);
         e = rq.pop_front();
         checks++;
         if (bus.io_q !== e) begin
            fails++;
            $display("FAIL read_comp%0d: got %h, expected %h", i, bus.io_q, e);
         end
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.pal_a !== 8'h06) begin
         fails++;
         $display("FAIL auto_prefetch: got busy=%b pal_a=%h, expected 1 06", bus.busy, bus.pal_a);
      end
      wait_not_busy(cyc);
      rq.push_back(8'h0C);
      cpu_read(2'd2);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL next_entry_r: got %h, expected %h", bus.io_q, e);
      end
   endtask

   task automatic test_busy_rules;
      logic [7:0] e;
      int         cyc;
      cpu_write(2'd0, 8'h05);
      rq.push_back(8'h00);
      cpu_read(2'd2);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL read_busy: got %h, expected %h", bus.io_q, e);
      end
      wait_not_busy(cyc);
      checks++;
      if (cyc >= 50) begin
         fails++;
         $display("FAIL busy_timeout: got %0d clocks, expected < 50", cyc);
      end
      rq.push_back(8'h2A);
      cpu_read(2'd2);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL rcomp_held: got %h, expected %h", bus.io_q, e);
      end
      rq.push_back(8'h00);
      cpu_read(2'd3);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL read_a3: got %h, expected %h", bus.io_q, e);
      end
      cpu_write(2'd1, 8'h77);
      rq.push_back(8'h00);
      cpu_read(2'd2);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL read_wmode: got %h, expected %h", bus.io_q, e);
      end
      rq.push_back(8'h77);
      cpu_read(2'd1);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL widx_read: got %h, expected %h", bus.io_q, e);
      end
      // Write and read together: write wins, io_q keeps 0x77.
      bus.io_a  = 2'd1;
      bus.io_d  = 8'h42;
      bus.io_wr = 1'b1;
      bus.io_rd = 1'b1;
      @(negedge clock);
      bus.io_wr = 1'b0;
      bus.io_rd = 1'b0;
      checks++;
      if (bus.io_q !== 8'h77) begin
         fails++;
         $display("FAIL wr_rd_hold: got %h, expected 77", bus.io_q);
      end
      rq.push_back(8'h42);
      cpu_read(2'd1);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL wr_rd_write: got %h, expected %h", bus.io_q, e);
      end
   endtask

   task automatic test_port_conflict;
      logic [7:0] e;
      logic [7:0] exp3[3];
      int         cyc;
      exp3 = '{8'h04, 8'h08, 8'h0C};
      cpu_write(2'd1, 8'h21);
      wq.push_back('{a: 8'h21, d: 12'h123});
      cpu_write(2'd2, 8'h04);
      cpu_write(2'd2, 8'h08);
      cpu_write(2'd2, 8'h0C);
      // Prefetch request lands on the clock the B write takes the port.
      cpu_write(2'd0, 8'h05);
      checks++;
      if (bus.pal_we !== 1'b1 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL conflict_order: got pal_we=%b busy=%b, expected 1 1", bus.pal_we, bus.busy);
      end
      wait_not_busy(cyc);
      checks++;
      if (cyc != 4) begin
         fails++;
         $display("FAIL stall_len: got %0d clocks, expected 4", cyc);
      end
      rq.push_back(8'h2A);
      cpu_read(2'd2);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL stall_rbuf: got %h, expected %h", bus.io_q, e);
      end
      cpu_write(2'd0, 8'h21);
      wait_not_busy(cyc);
      for (int i = 0; i < 3; i++) begin
         rq.push_back(exp3[i]);
         cpu_read(2'd2);
         e = rq.pop_front();
         checks++;
         if (bus.io_q !== e) begin
            fails++;
            $display("FAIL conflict_entry%0d: got %h, expected %h", i, bus.io_q, e);
         end
      end
      wait_not_busy(cyc);
   endtask

   task automatic test_reset_mid;
      logic [7:0] e;
      cpu_write(2'd1, 8'h30);
      cpu_write(2'd2, 8'h3C);
      cpu_write(2'd2, 8'h14);
      @(negedge clock);
      cpu_write(2'd0, 8'h05);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.pal_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_prefetch: got busy=%b pal_we=%b, expected 0 0", bus.busy, bus.pal_we);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      rq.push_back(8'h00);
      cpu_read(2'd1);
      e = rq.pop_front();
      checks++;
      if (bus.io_q !== e) begin
         fails++;
         $display("FAIL reset_mid_widx: got %h, expected %h", bus.io_q, e);
      end
      // Data sequence after reset must start at R with widx = 0.
      wq.push_back('{a: 8'h00, d: 12'h246});
      cpu_write(2'd2, 8'h08);
      cpu_write(2'd2, 8'h10);
      cpu_write(2'd2, 8'h18);
      repeat (2) @(negedge clock);
      // Reset while a palette write pulse is on the port.
      cpu_write(2'd2, 8'h04);
      cpu_write(2'd2, 8'h04);
      cpu_write(2'd2, 8'h04);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.pal_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_we: got pal_we=%b, expected 0", bus.pal_we);
      end
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.io_a  = 2'd0;
      bus.io_wr = 1'b0;
      bus.io_rd = 1'b0;
      bus.io_d  = 8'h00;
      test_reset();
      test_write_path();
      test_wrap();
      test_read_back();
      test_busy_rules();
      test_port_conflict();
      test_reset_mid();
      repeat (3) @(negedge clock);
      checks++;
      if (wq.size() != 0) begin
         fails++;
         $display("FAIL pal_write_missing: got %0d writes outstanding, expected 0", wq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
